eth_traff_arb: RTL and testbench



---
 rtl/eth_traff_arb_if.sv | 35 +++
 rtl/eth_traff_arb.sv | 175 +++++++++++++++++
 tb/tb_eth_traff_arb.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_traff_arb_if.sv
// Avalon-ST bundle for the traffic arbiter: NUM_CH ingress channels plus one
// egress stream.
//   slave  : arbiter view (consumes in_*, tx_ready; drives in_ready, tx_*)
//   master : traffic-source / sink view (the mirror image)
interface eth_traff_arb_if #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned EMPTY_W = 5
);
    logic [NUM_CH*DATA_W-1:0]  in_data;
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH-1:0]         in_sop;
    logic [NUM_CH-1:0]         in_eop;
    logic [NUM_CH-1:0]         in_error;
    logic [NUM_CH*EMPTY_W-1:0] in_empty;
    logic [NUM_CH-1:0]         in_ready;

    logic                      tx_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_valid;
    logic                      tx_sop;
    logic                      tx_eop;
    logic                      tx_error;
    logic [EMPTY_W-1:0]        tx_empty;

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_error, in_empty, tx_ready,
        output in_ready, tx_data, tx_valid, tx_sop, tx_eop, tx_error, tx_empty
    );

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_error, in_empty, tx_ready,
        input  in_ready, tx_data, tx_valid, tx_sop, tx_eop, tx_error, tx_empty
    );
endinterface

// File: rtl/eth_traff_arb.sv
// Packet-level round-robin arbiter merging NUM_CH Avalon-ST channels onto one
// egress stream, with an Avalon-MM CSR block (ID, enable, counter clear,
// status, per-channel packet and discard counters).
// Ports:
//   clk, reset_n            single clock, async active-low reset
//   cfg_read/cfg_write      CSR strobes; cfg_address word address
//   cfg_wrdata/cfg_rddata   CSR data (rddata registered, held between reads)
//   st                      streaming bundle (eth_traff_arb_if.slave)
module eth_traff_arb #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned EMPTY_W = 5,
    parameter int unsigned INST_ID = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_read,
    input  logic          cfg_write,
    input  logic [15:0]   cfg_address,
    input  logic [31:0]   cfg_wrdata,
    output logic [31:0]   cfg_rddata,
    eth_traff_arb_if.slave st
);
    localparam int unsigned GNT_W = 4;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned CSR_W = 32;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e                        state_q, state_d;
    logic [GNT_W-1:0]              grant_q, grant_d;
    logic [GNT_W-1:0]              last_grant_q, last_grant_d;
    logic [NUM_CH-1:0]             enable_q, enable_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  disc_cnt_q, disc_cnt_d;
    logic [CSR_W-1:0]              rddata_q, rddata_d;

    logic [NUM_CH-1:0]  eligible_c;
    logic [NUM_CH-1:0]  in_ready_c;
    logic [NUM_CH-1:0]  pkt_inc_c;
    logic [NUM_CH-1:0]  disc_inc_c;
    logic               enable_wr_c;
    logic               clr_c;
    logic [CSR_W-1:0]   rd_val_c;
    logic               unused_c;

    logic [DATA_W-1:0]  tx_data_c;
    logic [EMPTY_W-1:0] tx_empty_c;
    logic               tx_valid_c;
    logic               tx_sop_c;
    logic               tx_eop_c;
    logic               tx_error_c;

    // CSR write decode; the counter clear exists only in the write cycle
    assign enable_wr_c = cfg_write && (cfg_address == 16'h0001);
    assign clr_c       = cfg_write && (cfg_address == 16'h0002) && cfg_wrdata[0];
    assign unused_c    = ^cfg_wrdata;

    assign eligible_c  = enable_q & st.in_valid & st.in_sop;

    // Arbitration FSM: round-robin grant in IDLE, transparent channel mux in BUSY
    always_comb begin : fsm_comb
        int unsigned idx;
        logic        found;
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        in_ready_c   = '0;
        pkt_inc_c    = '0;
        disc_inc_c   = '0;
        tx_data_c    = '0;
        tx_empty_c   = '0;
        tx_valid_c   = 1'b0;
        tx_sop_c     = 1'b0;
        tx_eop_c     = 1'b0;
        tx_error_c   = 1'b0;
        idx          = 0;
        found        = 1'b0;
        case (state_q)
            IDLE: begin
                // Mid-packet beats arriving with no packet open are drained and counted
                in_ready_c = st.in_valid & ~st.in_sop;
                disc_inc_c = st.in_valid & ~st.in_sop;
                for (int unsigned i = 1; i <= NUM_CH; i++) begin
                    idx = 32'(last_grant_q) + i;
                    if (idx >= NUM_CH) idx = idx - NUM_CH;
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        if (!found && (idx == c) && eligible_c[c]) begin
                            found        = 1'b1;
                            grant_d      = GNT_W'(c);
                            last_grant_d = GNT_W'(c);
                            state_d      = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                // Enable is deliberately ignored here so an open packet always completes
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (grant_q == GNT_W'(c)) begin
                        tx_data_c     = st.in_data[c*DATA_W +: DATA_W];
                        tx_empty_c    = st.in_empty[c*EMPTY_W +: EMPTY_W];
                        tx_valid_c    = st.in_valid[c];
                        tx_sop_c      = st.in_sop[c];
                        tx_eop_c      = st.in_eop[c];
                        tx_error_c    = st.in_error[c];
                        in_ready_c[c] = st.tx_ready;
                        if (st.in_valid[c] && st.tx_ready && st.in_eop[c]) begin
                            state_d      = IDLE;
                            pkt_inc_c[c] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Enable register and counters; clear wins over a same-cycle increment
    always_comb begin : cnt_comb
        enable_d = enable_wr_c ? cfg_wrdata[NUM_CH-1:0] : enable_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            pkt_cnt_d[c]  = clr_c ? '0 : pkt_cnt_q[c]  + CNT_W'(pkt_inc_c[c]);
            disc_cnt_d[c] = clr_c ? '0 : disc_cnt_q[c] + CNT_W'(disc_inc_c[c]);
        end
    end

    // CSR read mux; pre-write values are returned on a simultaneous write
    always_comb begin : csr_rd_comb
        rd_val_c = '0;
        case (cfg_address)
            16'h0000: rd_val_c = {8'(INST_ID), 8'(NUM_CH), 16'(DATA_W)};
            16'h0001: rd_val_c = CSR_W'(enable_q);
            16'h0003: rd_val_c = {24'h0, grant_q, 3'b000, state_q == BUSY};
            default:  rd_val_c = '0;
        endcase
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (cfg_address == 16'h0010 + 16'(c)) rd_val_c = pkt_cnt_q[c];
            if (cfg_address == 16'h0020 + 16'(c)) rd_val_c = disc_cnt_q[c];
        end
        rddata_d = cfg_read ? rd_val_c : rddata_q;
    end

    // State and CSR registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GNT_W'(NUM_CH - 1);
            enable_q     <= '0;
            pkt_cnt_q    <= '0;
            disc_cnt_q   <= '0;
            rddata_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            enable_q     <= enable_d;
            pkt_cnt_q    <= pkt_cnt_d;
            disc_cnt_q   <= disc_cnt_d;
            rddata_q     <= rddata_d;
        end
    end

    // Reset also blocks the IDLE drain path so nothing is accepted while held
    assign st.in_ready = in_ready_c & {NUM_CH{reset_n}};
    assign st.tx_data  = tx_data_c;
    assign st.tx_empty = tx_empty_c;
    assign st.tx_valid = tx_valid_c;
    assign st.tx_sop   = tx_sop_c;
    assign st.tx_eop   = tx_eop_c;
    assign st.tx_error = tx_error_c;
    assign cfg_rddata  = rddata_q;

endmodule

// File: tb/tb_eth_traff_arb.sv
// Directed bench for eth_traff_arb: per-channel packet sources, egress beat log
// and CSR read/write tasks; each scenario task checks its own expectations.
module tb_eth_traff_arb;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned DATA_W  = 256;
    localparam int unsigned EMPTY_W = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_read;
    logic        cfg_write;
    logic [15:0] cfg_address;
    logic [31:0] cfg_wrdata;
    logic [31:0] cfg_rddata;

    eth_traff_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) st();

    eth_traff_arb #(.NUM_CH(4), .DATA_W(256), .EMPTY_W(5), .INST_ID(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_read    (cfg_read),
        .cfg_write   (cfg_write),
        .cfg_address (cfg_address),
        .cfg_wrdata  (cfg_wrdata),
        .cfg_rddata  (cfg_rddata),
        .st          (st)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int src_len  [NUM_CH];
    int src_pos  [NUM_CH];
    int src_left [NUM_CH];
    int src_pkt  [NUM_CH];
    bit src_nosop[NUM_CH];
    int hs_cnt   [NUM_CH];
    bit txr_toggle = 1'b0;

    int q_ch[$];
    int q_pos[$];
    int q_cyc[$];
    int q_emp[$];
    int q_tag[$];
    bit q_sop[$];
    bit q_eop[$];
    bit q_err[$];

    task automatic src_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            src_len[c] = 1; src_pos[c] = 0; src_left[c] = 0;
            src_pkt[c] = 0; src_nosop[c] = 1'b0; hs_cnt[c] = 0;
        end
    endtask

    function automatic bit src_busy();
        bit b = 1'b0;
        for (int c = 0; c < NUM_CH; c++) if (src_left[c] > 0) b = 1'b1;
        return b;
    endfunction

    // Beat payload low word = {channel, packet, beat, 0xA5}; empty = beat index
    task automatic drive_inputs();
        for (int c = 0; c < NUM_CH; c++) begin
            logic [DATA_W-1:0] d;
            d = '0;
            if (src_left[c] > 0) begin
                d[31:0] = {8'(c), 8'(src_pkt[c]), 8'(src_pos[c]), 8'hA5};
                st.in_valid[c] = 1'b1;
                st.in_sop[c]   = !src_nosop[c] && (src_pos[c] == 0);
                st.in_eop[c]   = !src_nosop[c] && (src_pos[c] == src_len[c] - 1);
                st.in_error[c] = st.in_eop[c] && (c == 3);
                st.in_empty[c*EMPTY_W +: EMPTY_W] = EMPTY_W'(src_pos[c]);
            end else begin
                st.in_valid[c] = 1'b0;
                st.in_sop[c]   = 1'b0;
                st.in_eop[c]   = 1'b0;
                st.in_error[c] = 1'b0;
                st.in_empty[c*EMPTY_W +: EMPTY_W] = '0;
            end
            st.in_data[c*DATA_W +: DATA_W] = d;
        end
        st.tx_ready = txr_toggle ? cyc[0] : 1'b1;
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, log handshakes
    task automatic tick();
        drive_inputs();
        #1;
        if (st.tx_valid && st.tx_ready) begin
            q_ch.push_back(int'(st.tx_data[31:24]));
            q_pos.push_back(int'(st.tx_data[15:8]));
            q_tag.push_back(int'(st.tx_data[7:0]));
            q_emp.push_back(int'(st.tx_empty));
            q_sop.push_back(st.tx_sop);
            q_eop.push_back(st.tx_eop);
            q_err.push_back(st.tx_error);
            q_cyc.push_back(cyc);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (st.in_valid[c] && st.in_ready[c]) begin
                hs_cnt[c]++;
                src_pos[c]++;
                if (src_pos[c] == src_len[c]) begin
                    src_pos[c] = 0;
                    src_left[c]--;
                    src_pkt[c]++;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic csr_write(input logic [15:0] a, input logic [31:0] d);
        cfg_write = 1'b1; cfg_address = a; cfg_wrdata = d;
        tick();
        cfg_write = 1'b0;
    endtask

    task automatic csr_read(input logic [15:0] a, output logic [31:0] d);
        cfg_read = 1'b1; cfg_address = a;
        tick();
        cfg_read = 1'b0;
        d = cfg_rddata;
    endtask

    task automatic wait_src_done(input int budget, input string name);
        int n = 0;
        while (src_busy() && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (src_busy()) begin
            errors++;
            $display("FAIL %s: sources not drained after %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset_n = 1'b0; cfg_read = 1'b0; cfg_write = 1'b0;
        cfg_address = '0; cfg_wrdata = '0;
        src_clear();
        src_nosop[3] = 1'b1; src_len[3] = 2; src_left[3] = 1;
        drive_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (st.tx_valid !== 1'b0 || st.tx_data !== '0 || st.tx_sop !== 1'b0) begin
            errors++; $display("FAIL reset_tx: valid=%b sop=%b (required 0, data 0)", st.tx_valid, st.tx_sop);
        end
        checks++;
        if (st.in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready: got %b required 0000", st.in_ready);
        end
        checks++;
        if (cfg_rddata !== 32'h0) begin
            errors++; $display("FAIL reset_rddata: got %h required 0", cfg_rddata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        src_clear();
        csr_read(16'h0003, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required 0", r); end
        csr_read(16'h0001, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_enable: got %h required 0", r); end
    endtask

    task automatic test_id_regs();
        logic [31:0] r;
        csr_read(16'h0000, r);
        checks++;
        if (r !== 32'h03040100) begin errors++; $display("FAIL id_reg: got %h required 03040100", r); end
        tick();
        checks++;
        if (cfg_rddata !== 32'h03040100) begin
            errors++; $display("FAIL rddata_hold: got %h required 03040100", cfg_rddata);
        end
        csr_read(16'h0014, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL oob_channel_read: got %h required 0", r); end
        csr_write(16'h0002, 32'h0);
        csr_read(16'h0002, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL clear_reg_read: got %h required 0", r); end
        csr_write(16'h0011, 32'h5);
        csr_read(16'h0011, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL ro_counter_write: got %h required 0", r); end
    endtask

    task automatic test_round_robin();
        logic [31:0] r;
        int base, bad, exp_ch[5], k;
        exp_ch = '{0, 1, 2, 3, 0};
        cfg_read = 1'b1; cfg_write = 1'b1; cfg_address = 16'h0001; cfg_wrdata = 32'hF;
        tick();
        cfg_read = 1'b0; cfg_write = 1'b0;
        checks++;
        if (cfg_rddata !== 32'h0) begin
            errors++; $display("FAIL rw_same_addr: got %h required 0 (pre-write)", cfg_rddata);
        end
        csr_read(16'h0001, r);
        checks++;
        if (r !== 32'hF) begin errors++; $display("FAIL enable_readback: got %h required f", r); end
        src_clear();
        for (int c = 0; c < NUM_CH; c++) begin src_len[c] = 3; src_left[c] = 1; end
        src_left[0] = 2;
        base = q_ch.size();
        wait_src_done(100, "rr_drain");
        checks++;
        if (q_ch.size() - base != 15) begin
            errors++; $display("FAIL rr_beats: got %0d required 15", q_ch.size() - base);
        end else begin
            k = 0;
            for (int i = base; i < base + 15; i++) begin
                if (q_sop[i]) begin
                    checks++;
                    if (q_ch[i] != exp_ch[k]) begin
                        errors++; $display("FAIL rr_order pkt%0d: got ch%0d required ch%0d", k, q_ch[i], exp_ch[k]);
                    end
                    if (k > 0) begin
                        checks++;
                        if (q_cyc[i] - q_cyc[i-1] != 2) begin
                            errors++; $display("FAIL rr_bubble pkt%0d: gap %0d required 2", k, q_cyc[i] - q_cyc[i-1]);
                        end
                    end
                    k++;
                end
            end
            bad = 0;
            for (int i = 0; i < 15; i++) begin
                int j = base + i;
                int p = i % 3;
                if (q_pos[j] != p || q_tag[j] != 'hA5 || q_emp[j] != p || q_sop[j] != (p == 0) ||
                    q_eop[j] != (p == 2) || q_err[j] != (p == 2 && q_ch[j] == 3)) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rr_beat_fields: %0d bad beats, required 0", bad); end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            csr_read(16'h0010 + 16'(c), r);
            checks++;
            if (r !== ((c == 0) ? 32'd2 : 32'd1)) begin
                errors++; $display("FAIL rr_pkt_cnt%0d: got %0d required %0d", c, r, (c == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_disable_mid_pkt();
        logic [31:0] r;
        int base, n, bad;
        src_clear();
        csr_write(16'h0002, 32'h1);
        csr_write(16'h0001, 32'h2);
        txr_toggle = 1'b1;
        src_len[1] = 4; src_left[1] = 1;
        base = q_ch.size();
        n = 0;
        while (q_ch.size() == base && n < 20) begin tick(); n++; end
        checks++;
        if (q_ch.size() == base) begin errors++; $display("FAIL dis_first_beat: no beat within 20 cycles"); end
        csr_write(16'h0001, 32'h0);
        wait_src_done(40, "dis_drain");
        checks++;
        if (q_ch.size() - base != 4) begin
            errors++; $display("FAIL dis_beats: got %0d required 4", q_ch.size() - base);
        end else begin
            bad = 0;
            for (int i = 0; i < 4; i++) begin
                int j = base + i;
                if (q_ch[j] != 1 || q_pos[j] != i || q_sop[j] != (i == 0) || q_eop[j] != (i == 3)) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL dis_beat_fields: %0d bad beats, required 0", bad); end
        end
        txr_toggle = 1'b0;
        src_left[1] = 1;
        base = q_ch.size();
        repeat (10) tick();
        checks++;
        if (q_ch.size() != base) begin
            errors++; $display("FAIL dis_no_grant: got %0d beats required 0", q_ch.size() - base);
        end
        csr_read(16'h0003, r);
        checks++;
        if (r !== 32'h10) begin errors++; $display("FAIL dis_status: got %h required 10", r); end
        csr_read(16'h0011, r);
        checks++;
        if (r !== 32'd1) begin errors++; $display("FAIL dis_pkt_cnt1: got %0d required 1", r); end
    endtask

    task automatic test_discard();
        logic [31:0] r;
        int base;
        src_clear();
        csr_write(16'h0002, 32'h1);
        csr_write(16'h0001, 32'h1);
        src_nosop[2] = 1'b1; src_len[2] = 5; src_left[2] = 1;
        base = q_ch.size();
        wait_src_done(30, "disc_drain");
        checks++;
        if (hs_cnt[2] != 5) begin errors++; $display("FAIL disc_ready_beats: got %0d required 5", hs_cnt[2]); end
        checks++;
        if (q_ch.size() != base) begin
            errors++; $display("FAIL disc_tx_valid: got %0d beats required 0", q_ch.size() - base);
        end
        csr_read(16'h0022, r);
        checks++;
        if (r !== 32'd5) begin errors++; $display("FAIL disc_cnt2: got %0d required 5", r); end
        csr_read(16'h0020, r);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL disc_cnt0: got %0d required 0", r); end
    endtask

    task automatic test_counter_wrap();
        logic [31:0] r;
        int c_eop;
        src_clear();
        csr_write(16'h0002, 32'h1);
        csr_write(16'h0001, 32'h3);
        force dut.pkt_cnt_q = {96'h0, 32'hFFFF_FFFF};
        tick();
        release dut.pkt_cnt_q;
        csr_read(16'h0010, r);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h required ffffffff", r); end
        src_len[0] = 3; src_left[0] = 1;
        wait_src_done(30, "wrap_drain");
        csr_read(16'h0010, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL wrap_pkt_cnt0: got %h required 0", r); end
        src_len[1] = 3; src_left[1] = 1;
        repeat (3) tick();
        c_eop = cyc;
        cfg_write = 1'b1; cfg_address = 16'h0002; cfg_wrdata = 32'h1;
        tick();
        cfg_write = 1'b0;
        checks++;
        if (q_cyc[$] != c_eop || !q_eop[$] || q_ch[$] != 1) begin
            errors++; $display("FAIL clr_eop_align: last beat cyc %0d eop %b ch%0d, required cyc %0d eop 1 ch1",
                               q_cyc[$], q_eop[$], q_ch[$], c_eop);
        end
        csr_read(16'h0011, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL clr_vs_inc: got %0d required 0", r); end
    endtask

    task automatic test_reset_mid_pkt();
        logic [31:0] r;
        int base, n;
        src_clear();
        csr_write(16'h0001, 32'h1);
        src_len[0] = 4; src_left[0] = 1;
        base = q_ch.size();
        n = 0;
        while (q_ch.size() == base && n < 10) begin tick(); n++; end
        checks++;
        if (q_ch.size() == base) begin errors++; $display("FAIL rst_first_beat: no beat within 10 cycles"); end
        drive_inputs();
        #1;
        checks++;
        if (st.tx_valid !== 1'b1) begin errors++; $display("FAIL rst_beat2_present: tx_valid %b required 1", st.tx_valid); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (st.tx_valid !== 1'b0 || st.in_ready !== 4'b0000 || st.tx_data !== '0) begin
            errors++; $display("FAIL rst_abort: tx_valid %b in_ready %b, required 0 and 0000", st.tx_valid, st.in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        reset_n = 1'b1;
        repeat (6) tick();
        checks++;
        if (q_ch.size() != base + 1) begin
            errors++; $display("FAIL rst_stale_beats: got %0d extra beats required 0", q_ch.size() - base - 1);
        end
        csr_read(16'h0001, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL rst_enable: got %h required 0", r); end
        csr_read(16'h0020, r);
        checks++;
        if (r !== 32'd3) begin errors++; $display("FAIL rst_disc_cnt0: got %0d required 3", r); end
    endtask

    initial begin
        test_reset();
        test_id_regs();
        test_round_robin();
        test_disable_mid_pkt();
        test_discard();
        test_counter_wrap();
        test_reset_mid_pkt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
